// File: rtl/rect_draw_sequencer.sv
// Rectangle-drawing controller: captures two corners with the record button,
// normalizes them into a box and walks its perimeter one pixel per handshake.
module rect_draw_sequencer #(
    parameter int COORD_W = 10,
    parameter int H_MAX   = 639,
    parameter int V_MAX   = 479
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               record_rect_pt,
    input  logic               draw_rectangle,
    input  logic               abort,
    input  logic [COORD_W-1:0] cursor_x,
    input  logic [COORD_W-1:0] cursor_y,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COORD_W-1:0] rect_x0,
    output logic [COORD_W-1:0] rect_y0,
    output logic [COORD_W-1:0] rect_x1,
    output logic [COORD_W-1:0] rect_y1,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PT1_HELD = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_TOP      = 3'd3;
    localparam logic [2:0] S_RIGHT    = 3'd4;
    localparam logic [2:0] S_BOTTOM   = 3'd5;
    localparam logic [2:0] S_LEFT     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_MAX);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    function automatic logic [COORD_W-1:0] clamp_x(input logic [COORD_W-1:0] v);
        return (v > H_LIM) ? H_LIM : v;
    endfunction

    function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] v);
        return (v > V_LIM) ? V_LIM : v;
    endfunction

    logic               rec_q;
    logic               rise;
    logic               fall;
    logic               accept;
    logic [COORD_W-1:0] cap_x;
    logic [COORD_W-1:0] cap_y;
    logic [COORD_W-1:0] p1_x;
    logic [COORD_W-1:0] p1_y;

    assign rise   = record_rect_pt & ~rec_q;
    assign fall   = ~record_rect_pt & rec_q;
    assign accept = pix_valid & pix_ready;
    assign cap_x  = clamp_x(cursor_x);
    assign cap_y  = clamp_y(cursor_y);
    assign busy   = (state == S_TOP) || (state == S_RIGHT) ||
                    (state == S_BOTTOM) || (state == S_LEFT);
    assign done   = (state == S_DONE);

    // Register the button level so edges can be detected against the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rec_q <= 1'b0;
        else     rec_q <= record_rect_pt;
    end

    // Corner capture, normalization and perimeter walk; segment ends are tested
    // before stepping so coordinates never wrap, and empty segments fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            p1_x      <= '0;
            p1_y      <= '0;
            rect_x0   <= '0;
            rect_y0   <= '0;
            rect_x1   <= '0;
            rect_y1   <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        p1_x  <= cap_x;
                        p1_y  <= cap_y;
                        state <= S_PT1_HELD;
                    end
                end
                S_PT1_HELD: begin
                    if (fall) begin
                        rect_x0 <= (p1_x < cap_x) ? p1_x : cap_x;
                        rect_x1 <= (p1_x < cap_x) ? cap_x : p1_x;
                        rect_y0 <= (p1_y < cap_y) ? p1_y : cap_y;
                        rect_y1 <= (p1_y < cap_y) ? cap_y : p1_y;
                        state   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (rise) begin
                        p1_x  <= cap_x;
                        p1_y  <= cap_y;
                        state <= S_PT1_HELD;
                    end else if (draw_rectangle) begin
                        pix_x     <= rect_x0;
                        pix_y     <= rect_y0;
                        pix_valid <= 1'b1;
                        state     <= S_TOP;
                    end
                end
                S_TOP: begin
                    if (accept) begin
                        if (pix_x < rect_x1) begin
                            pix_x <= pix_x + ONE;
                        end else if (rect_y1 > rect_y0) begin
                            pix_y <= rect_y0 + ONE;
                            state <= S_RIGHT;
                        end else begin
                            pix_valid <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_RIGHT: begin
                    if (accept) begin
                        if (pix_y < rect_y1) begin
                            pix_y <= pix_y + ONE;
                        end else if (rect_x1 > rect_x0) begin
                            pix_x <= rect_x1 - ONE;
                            state <= S_BOTTOM;
                        end else begin
                            pix_valid <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_BOTTOM: begin
                    if (accept) begin
                        if (pix_x > rect_x0) begin
                            pix_x <= pix_x - ONE;
                        end else if ((rect_y1 - rect_y0) > ONE) begin
                            pix_y <= rect_y1 - ONE;
                            state <= S_LEFT;
                        end else begin
                            pix_valid <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_LEFT: begin
                    if (accept) begin
                        if ((pix_y - ONE) > rect_y0) begin
                            pix_y <= pix_y - ONE;
                        end else begin
                            pix_valid <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                default: begin
                    state <= S_ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_draw_sequencer.sv
// Directed bench for rect_draw_sequencer: capture, draw, stall, degenerate boxes,
// clamping, abort and asynchronous reset.
module tb_rect_draw_sequencer;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         record_rect_pt = 1'b0;
    logic         draw_rectangle = 1'b0;
    logic         abort = 1'b0;
    logic         pix_ready = 1'b0;
    logic [W-1:0] cursor_x = '0;
    logic [W-1:0] cursor_y = '0;
    logic         pix_valid;
    logic [W-1:0] pix_x, pix_y;
    logic [W-1:0] rect_x0, rect_y0, rect_x1, rect_y1;
    logic         busy, done;
    logic [2:0]   state;

    int n_checks = 0;
    int n_pass   = 0;
    int stable_err;
    logic [2*W-1:0] got_q[$];
    logic [2*W-1:0] exp_q[$];

    rect_draw_sequencer #(.COORD_W(W), .H_MAX(639), .V_MAX(479)) dut (
        .clk(clk), .rst(rst), .record_rect_pt(record_rect_pt),
        .draw_rectangle(draw_rectangle), .abort(abort),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_x1(rect_x1), .rect_y1(rect_y1),
        .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int ax, input int ay, input int bx, input int by);
        cursor_x = ax[W-1:0];
        cursor_y = ay[W-1:0];
        record_rect_pt = 1'b1;
        tick();
        check("cap_pt1_state", 32'(state), 1);
        cursor_x = bx[W-1:0];
        cursor_y = by[W-1:0];
        record_rect_pt = 1'b0;
        tick();
        check("cap_armed_state", 32'(state), 2);
    endtask

    task automatic check_rect(input int x0, input int y0, input int x1, input int y1);
        check("rect_x0", 32'(rect_x0), x0);
        check("rect_y0", 32'(rect_y0), y0);
        check("rect_x1", 32'(rect_x1), x1);
        check("rect_y1", 32'(rect_y1), y1);
    endtask

    task automatic start_draw(input int x0, input int y0);
        draw_rectangle = 1'b1;
        tick();
        draw_rectangle = 1'b0;
        check("draw_state_top", 32'(state), 3);
        check("draw_valid", 32'(pix_valid), 1);
        check("draw_busy", 32'(busy), 1);
        check("draw_first_x", 32'(pix_x), x0);
        check("draw_first_y", 32'(pix_y), y0);
    endtask

    // Expected perimeter listed segment by segment from the box corners.
    task automatic build_exp(input int x0, input int y0, input int x1, input int y1);
        exp_q.delete();
        for (int x = x0; x <= x1; x++) exp_q.push_back({x[W-1:0], y0[W-1:0]});
        if (y1 > y0) begin
            for (int y = y0 + 1; y <= y1; y++) exp_q.push_back({x1[W-1:0], y[W-1:0]});
            if (x1 > x0) begin
                for (int x = x1 - 1; x >= x0; x--) exp_q.push_back({x[W-1:0], y1[W-1:0]});
                for (int y = y1 - 1; y > y0; y--) exp_q.push_back({x0[W-1:0], y[W-1:0]});
            end
        end
    endtask

    // mode 0: ready always; mode 1: ready 1,0,0,1; mode 2: ready always, button toggling.
    task automatic walk(input int mode, input int budget);
        bit prev_stall;
        logic [2*W:0] prev;
        prev_stall = 1'b0;
        prev = '0;
        got_q.delete();
        stable_err = 0;
        for (int k = 0; k < budget; k++) begin
            if (mode == 1) pix_ready = ((k % 4) == 0) || ((k % 4) == 3);
            else           pix_ready = 1'b1;
            if (mode == 2) record_rect_pt = ~record_rect_pt;
            if (prev_stall && ({pix_valid, pix_x, pix_y} !== prev)) stable_err++;
            prev_stall = pix_valid && !pix_ready;
            prev = {pix_valid, pix_x, pix_y};
            if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y});
            tick();
            if (done) break;
        end
        check("walk_done_seen", 32'(done), 1);
        check("walk_done_valid_low", 32'(pix_valid), 0);
        check("walk_done_state", 32'(state), 7);
        pix_ready = 1'b0;
        record_rect_pt = 1'b0;
        tick();
        check("after_done_state", 32'(state), 2);
        check("after_done_pulse", 32'(done), 0);
    endtask

    task automatic compare_walk(input string tag);
        int mm;
        mm = 0;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) mm++;
        end
        check({tag, "_mismatches"}, 32'(mm), 0);
    endtask

    initial begin
        int t1x[10];
        int t1y[10];
        t1x = '{10, 11, 12, 13, 13, 13, 12, 11, 10, 10};
        t1y = '{20, 20, 20, 20, 21, 22, 22, 22, 22, 21};

        // Reset state
        tick();
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_pix_x", 32'(pix_x), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rect_x1", 32'(rect_x1), 0);
        rst = 1'b0;
        tick();

        // Small box, full-speed walk, hand-listed order
        capture(10, 20, 13, 22);
        check_rect(10, 20, 13, 22);
        start_draw(10, 20);
        walk(0, 50);
        check("t1_count", 32'(got_q.size()), 10);
        for (int i = 0; i < 10; i++) begin
            check("t1_pix_x", 32'(got_q[i][2*W-1:W]), t1x[i]);
            check("t1_pix_y", 32'(got_q[i][W-1:0]), t1y[i]);
        end

        // Reversed corners are normalized; 700-pixel perimeter
        capture(300, 200, 100, 50);
        check_rect(100, 50, 300, 200);
        start_draw(100, 50);
        walk(0, 1000);
        build_exp(100, 50, 300, 200);
        compare_walk("t2");
        check("t2_first", 32'(got_q[0]), 32'({10'd100, 10'd50}));
        check("t2_last", 32'(got_q[got_q.size() - 1]), 32'({10'd100, 10'd51}));

        // Back-pressure: redraw previous box with ready stalling
        start_draw(100, 50);
        walk(1, 3000);
        compare_walk("t3_stall");
        check("t3_stable_err", 32'(stable_err), 0);

        // Degenerate boxes
        capture(5, 5, 5, 5);
        start_draw(5, 5);
        walk(0, 20);
        build_exp(5, 5, 5, 5);
        compare_walk("t4_point");
        check("t4_point_n", 32'(got_q.size()), 1);

        capture(0, 7, 4, 7);
        start_draw(0, 7);
        walk(0, 20);
        build_exp(0, 7, 4, 7);
        compare_walk("t4_row");
        check("t4_row_n", 32'(got_q.size()), 5);

        capture(639, 0, 639, 3);
        start_draw(639, 0);
        walk(0, 20);
        build_exp(639, 0, 639, 3);
        compare_walk("t4_col");
        check("t4_col_n", 32'(got_q.size()), 4);

        // Clamping on capture; button activity ignored while walking
        capture(700, 500, 600, 400);
        check_rect(600, 400, 639, 479);
        start_draw(600, 400);
        walk(2, 400);
        build_exp(600, 400, 639, 479);
        compare_walk("t5_clamp");
        check("t5_clamp_n", 32'(got_q.size()), 236);

        // abort after the third accepted pixel
        capture(10, 20, 13, 22);
        start_draw(10, 20);
        pix_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_pre_abort_x", 32'(pix_x), 13);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pix_ready = 1'b0;
        check("t6_abort_state", 32'(state), 0);
        check("t6_abort_valid", 32'(pix_valid), 0);
        check("t6_abort_busy", 32'(busy), 0);
        check("t6_abort_rect_kept", 32'(rect_x1), 13);
        tick();
        tick();
        check("t6_no_done", 32'(done), 0);
        check("t6_stay_idle", 32'(state), 0);

        // Asynchronous reset in the middle of a walk
        capture(10, 20, 13, 22);
        start_draw(10, 20);
        pix_ready = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_valid", 32'(pix_valid), 0);
        check("t6_arst_state", 32'(state), 0);
        check("t6_arst_busy", 32'(busy), 0);
        check("t6_arst_rect_x0", 32'(rect_x0), 0);
        check("t6_arst_pix_x", 32'(pix_x), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
